usb_rx_packet: RTL and testbench
================================

Name: usb_rx_packet

Overview:
- Full-speed USB 1.1 receive front end. Samples the synchronized D+/D- pair, then performs NRZI decoding, bit unstuffing, SYNC detection, PID checking and EOP detection.
- Payload bytes go to the downstream receive FIFO through its write port (w_enable/w_data). The block honours that FIFO's full flag.
- Reports the PID, packet completion and error status to the protocol controller.

Parameters:
- CLKS_PER_BIT, 8, clk cycles per USB bit time (96 MHz clk / 12 Mbps). Must be ≥4 and even.
- MAX_BYTES, 64, maximum payload bytes per packet (including CRC bytes). The byte after that limit is an error.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; one clock, asynchronous and active-high
- d_plus  input  1  D+ line, already 2-flop synchronized; idle J = 1
- d_minus  input  1  D- line, already synchronized; idle J = 0
- fifo_full  input  1  full flag from downstream FIFO
- w_enable  output  1  one-cycle FIFO write strobe
- w_data  output  8  byte written when w_enable=1 (first received bit in bit 0)
- rcving  output  1  high from SYNC start until packet end
- rx_pid  output  4  PID of the last packet whose PID check passed
- rx_done  output  1  one-cycle pulse on clean EOP
- rx_error  output  1  sticky error; cleared when the next packet's SYNC begins
- byte_count  output  7  payload bytes written for the current/last packet

Behaviour:
- Reset: all outputs 0; state IDLE; NRZI previous level = J (1).
- Bit timing:
  - Counter 0..CLKS_PER_BIT-1 restarts at 0 on every D+ transition.
  - Sample strobe fires at count CLKS_PER_BIT/2-1.
  - Only strobed samples feed the decoder.
- Line decode at strobe:
  - SE0 (both lines 0) → EOP symbol.
  - Both lines 1 → SE1, an error.
  - Otherwise: bit = 1 if D+ equals the previous sampled D+, else 0.
- Unstuff: a 1s counter increments on each 1 and clears on 0. After six consecutive 1s:
  - next bit 0 → discarded (the counter clears on it);
  - next bit 1 → stuff error.
- Shift register, LSB first. A byte completes on the 8th kept bit.
- State machine:
  - IDLE: leaves on the first strobe sampling K (D+=0, D-=1) → SYNC. In the same transition: rcving=1, rx_error=0, byte_count=0.
  - SYNC: collects 8 bits. Byte must equal 0x80, else error.
  - PID: collects 8 bits. Check byte[7:4] == ~byte[3:0].
    - Pass → rx_pid=byte[3:0], go to DATA.
    - Fail → error; rx_pid holds its old value.
  - DATA: each completed byte →
    - fifo_full=0 → w_enable=1 for exactly one cycle, next clk after the completing strobe; w_data=byte; byte_count+1.
    - fifo_full=1 at that cycle → byte dropped, error.
    - byte_count already MAX_BYTES → error.
    - EOP symbol seen → EOP.
  - EOP: requires a second consecutive SE0 strobe, then a J strobe.
    - Success → rx_done pulse, rcving=0, IDLE.
    - Non-J after SE0 → error.
  - ERR: rx_error=1; no further FIFO writes. Waits for SE0 followed by J, then → IDLE with rcving=0 and no rx_done.
- EOP with a partial byte (bit count not a multiple of 8) → error. EOP in SYNC/PID → error.
- Error entry from any state: rx_error set same cycle, state ERR.
- rst asserted mid-packet: immediate return to reset values; no w_enable is emitted after rst.
- w_enable is never high two consecutive cycles. Minimum spacing is 8·CLKS_PER_BIT cycles.

Test Plan:
- Reset then idle J for 100 cycles → all outputs 0, no w_enable.
- Sequence SYNC, PID 0xC3 (DATA0), data bytes 0x3F, 0xA5, then EOP (2×SE0, J) → rx_pid=0x3; two w_enable pulses with w_data 0x3F then 0xA5 (0x3F has six consecutive 1s, so a stuff bit is inserted and removed); byte_count=2; rx_done pulse; rx_error=0.
- PID 0xC4 (check fails) → rx_error=1, rx_pid unchanged, no writes. After EOP: rcving=0, no rx_done. Next valid packet clears rx_error at SYNC.
- Six 1s followed by a stuffed 1 inside the data → rx_error=1, no further writes.
- fifo_full=1 when the second data byte completes → only the first byte written, rx_error=1, byte_count=1.
- EOP after 12 data bits; separately, rst pulse mid-DATA → respectively rx_error=1 with no rx_done; and all outputs 0 within one cycle of rst rising.

Source files
------------

// File: rtl/usb_rx_packet.sv
// Full-speed USB receive front end: recovers bits from the D+/D- pair, decodes NRZI,
// removes stuffed bits, checks SYNC and PID, and writes payload bytes to a FIFO.
module usb_rx_packet #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned MAX_BYTES    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_plus,
    input  logic       d_minus,
    input  logic       fifo_full,
    output logic       w_enable,
    output logic [7:0] w_data,
    output logic       rcving,
    output logic [3:0] rx_pid,
    output logic       rx_done,
    output logic       rx_error,
    output logic [6:0] byte_count
);
    localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int unsigned STROBE_AT = CLKS_PER_BIT / 2 - 1;
    localparam int unsigned STUFF_RUN = 6;

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_PID, S_DATA, S_EOP1, S_EOP2, S_ERR
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dp_q;
    logic             prev_q;
    logic [6:0]       sr_q;
    logic [2:0]       bit_cnt_q;
    logic [2:0]       ones_q;
    logic             err_se0_q;
    logic             w_enable_q;
    logic [7:0]       w_data_q;
    logic             rcving_q;
    logic [3:0]       rx_pid_q;
    logic             rx_done_q;
    logic             rx_error_q;
    logic [6:0]       byte_count_q;

    logic       strobe, se0, se1, j_sym, k_sym, data_sym, bit_val, at_run;
    logic       kept, byte_done, in_pkt, byte_bad, fail;
    logic [7:0] sr_d;

    // Symbol decode at the mid-bit strobe and error detection for the current state
    always_comb begin
        strobe    = (cnt_q == CNT_W'(STROBE_AT));
        se0       = !d_plus && !d_minus;
        se1       = d_plus && d_minus;
        j_sym     = d_plus && !d_minus;
        k_sym     = !d_plus && d_minus;
        data_sym  = j_sym || k_sym;
        bit_val   = (d_plus == prev_q);
        at_run    = (ones_q == 3'(STUFF_RUN));
        kept      = data_sym && !at_run;
        sr_d      = {bit_val, sr_q};
        byte_done = kept && (bit_cnt_q == 3'd7);
        in_pkt    = (state_q == S_SYNC) || (state_q == S_PID) || (state_q == S_DATA);
        byte_bad  = 1'b0;
        case (state_q)
            S_SYNC:  byte_bad = (sr_d != 8'h80);
            S_PID:   byte_bad = (sr_d[7:4] != ~sr_d[3:0]);
            S_DATA:  byte_bad = (byte_count_q == 7'(MAX_BYTES)) || fifo_full;
            default: byte_bad = 1'b0;
        endcase
        fail = 1'b0;
        if (in_pkt) begin
            fail = se1
                || (se0 && !((state_q == S_DATA) && (bit_cnt_q == 3'd0)))
                || (data_sym && at_run && bit_val)
                || (byte_done && byte_bad);
        end else if (state_q == S_EOP1) begin
            fail = !se0;
        end else if (state_q == S_EOP2) begin
            fail = !j_sym;
        end
        fail = fail && strobe;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            dp_q         <= 1'b1;
            prev_q       <= 1'b1;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            ones_q       <= '0;
            err_se0_q    <= 1'b0;
            w_enable_q   <= 1'b0;
            w_data_q     <= '0;
            rcving_q     <= 1'b0;
            rx_pid_q     <= '0;
            rx_done_q    <= 1'b0;
            rx_error_q   <= 1'b0;
            byte_count_q <= '0;
        end else begin
            w_enable_q <= 1'b0;
            rx_done_q  <= 1'b0;
            dp_q       <= d_plus;
            // Bit clock realigns on every D+ edge
            if ((d_plus != dp_q) || (cnt_q == CNT_W'(CLKS_PER_BIT - 1))) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (strobe) begin
                prev_q <= d_plus;
                if (fail) begin
                    state_q    <= S_ERR;
                    rx_error_q <= 1'b1;
                    err_se0_q  <= se0;
                end else begin
                    case (state_q)
                        S_IDLE: begin
                            if (k_sym) begin
                                state_q      <= S_SYNC;
                                rcving_q     <= 1'b1;
                                rx_error_q   <= 1'b0;
                                byte_count_q <= '0;
                                sr_q         <= sr_d[7:1];
                                bit_cnt_q    <= 3'd1;
                                ones_q       <= '0;
                            end
                        end
                        S_SYNC, S_PID, S_DATA: begin
                            if (se0) begin
                                state_q <= S_EOP1;
                            end else if (kept) begin
                                ones_q    <= bit_val ? ones_q + 3'd1 : 3'd0;
                                sr_q      <= sr_d[7:1];
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                if (byte_done) begin
                                    if (state_q == S_SYNC) begin
                                        state_q <= S_PID;
                                    end else if (state_q == S_PID) begin
                                        state_q  <= S_DATA;
                                        rx_pid_q <= sr_d[3:0];
                                    end else begin
                                        w_enable_q   <= 1'b1;
                                        w_data_q     <= sr_d;
                                        byte_count_q <= byte_count_q + 7'd1;
                                    end
                                end
                            end else begin
                                ones_q <= '0;
                            end
                        end
                        S_EOP1: state_q <= S_EOP2;
                        S_EOP2: begin
                            state_q   <= S_IDLE;
                            rcving_q  <= 1'b0;
                            rx_done_q <= 1'b1;
                        end
                        S_ERR: begin
                            // Leave only after a line reset: SE0 then J
                            if (se0) begin
                                err_se0_q <= 1'b1;
                            end else if (j_sym && err_se0_q) begin
                                state_q   <= S_IDLE;
                                rcving_q  <= 1'b0;
                                err_se0_q <= 1'b0;
                            end else begin
                                err_se0_q <= 1'b0;
                            end
                        end
                        default: state_q <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign w_enable   = w_enable_q;
    assign w_data     = w_data_q;
    assign rcving     = rcving_q;
    assign rx_pid     = rx_pid_q;
    assign rx_done    = rx_done_q;
    assign rx_error   = rx_error_q;
    assign byte_count = byte_count_q;
endmodule

// File: tb/tb_usb_rx_packet.sv
// Bench for usb_rx_packet: encodes byte-level packets onto D+/D-, predicts FIFO writes
// and packet status from the byte list, and checks them with a queue-based monitor.
`timescale 1ns/1ps
module tb_usb_rx_packet;
    localparam int CPB  = 8;
    localparam int MAXB = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_plus;
    logic       d_minus;
    logic       fifo_full;
    logic       w_enable;
    logic [7:0] w_data;
    logic       rcving;
    logic [3:0] rx_pid;
    logic       rx_done;
    logic       rx_error;
    logic [6:0] byte_count;

    usb_rx_packet #(.CLKS_PER_BIT(CPB), .MAX_BYTES(MAXB)) dut (
        .clk        (clk),
        .rst        (rst),
        .d_plus     (d_plus),
        .d_minus    (d_minus),
        .fifo_full  (fifo_full),
        .w_enable   (w_enable),
        .w_data     (w_data),
        .rcving     (rcving),
        .rx_pid     (rx_pid),
        .rx_done    (rx_done),
        .rx_error   (rx_error),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    int         total;
    int         bad;
    int         done_seen;
    logic [7:0] exp_q[$];
    logic [7:0] pkt[$];
    logic [3:0] model_pid;
    logic       prev_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic drive(input logic dp, input logic dm);
        d_plus  = dp;
        d_minus = dm;
        repeat (CPB) @(negedge clk);
    endtask

    // Sends SYNC, pid, pkt[] and extra_bits random bits, then EOP. Expected results
    // come from byte positions: a byte is written only if it fully arrives before
    // any stuff violation, the FIFO-full point and the MAX_BYTES limit.
    task automatic send(input logic [7:0] pid, input bit stuff_en, input int full_idx,
                        input int extra_bits, input int abort_bit);
        bit         raw[$];
        logic [7:0] all[$];
        int         run, err_bit, exp_cnt, nbytes;
        bit         exp_err, lvl;
        nbytes = pkt.size();
        all.push_back(8'h80);
        all.push_back(pid);
        foreach (pkt[k]) all.push_back(pkt[k]);
        foreach (all[k]) for (int b = 0; b < 8; b++) raw.push_back(all[k][b]);
        for (int e = 0; e < extra_bits; e++) raw.push_back(1'($urandom_range(0, 1)));

        err_bit = raw.size();
        run     = 0;
        if (!stuff_en) begin
            foreach (raw[i]) begin
                run = raw[i] ? run + 1 : 0;
                if (run == 7 && err_bit == raw.size()) err_bit = i;
            end
        end
        exp_err = 1'b0;
        exp_cnt = 0;
        if (pid[7:4] != ~pid[3:0] || err_bit < 16) begin
            exp_err = 1'b1;
        end else begin
            model_pid = pid[3:0];
            for (int k = 0; k < nbytes; k++) begin
                if (16 + 8 * k + 7 >= err_bit || k >= MAXB || (full_idx >= 0 && k >= full_idx)) begin
                    exp_err = 1'b1;
                    break;
                end
                exp_q.push_back(pkt[k]);
                exp_cnt++;
            end
            if (extra_bits != 0 || err_bit < raw.size()) exp_err = 1'b1;
        end

        repeat (3) drive(1'b1, 1'b0);
        done_seen = 0;
        lvl       = 1'b1;
        run       = 0;
        foreach (raw[i]) begin
            if (i == abort_bit) begin
                check("writes_before_rst", exp_q.size(), exp_cnt - (abort_bit - 16) / 8);
                @(posedge clk);
                #1 rst = 1'b1;
                #1;
                check("outputs_on_rst", {w_enable, w_data, rcving, rx_pid, rx_done, rx_error, byte_count}, 0);
                exp_q.delete();
                model_pid = 4'h0;
                fifo_full = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                repeat (4) drive(1'b1, 1'b0);
                return;
            end
            if (full_idx >= 0 && i == 16 + 8 * full_idx) fifo_full = 1'b1;
            if (!raw[i]) lvl = !lvl;
            drive(lvl, !lvl);
            if (i == 0) begin
                check("sync_clears_error", rx_error, 0);
                check("rcving_at_sync", rcving, 1);
            end
            run = raw[i] ? run + 1 : 0;
            if (stuff_en && run == 6) begin
                lvl = !lvl;
                drive(lvl, !lvl);
                run = 0;
            end
        end
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        fifo_full = 1'b0;
        repeat (3) drive(1'b1, 1'b0);
        check("rx_done_count", done_seen, exp_err ? 0 : 1);
        check("rx_error", rx_error, exp_err);
        check("byte_count", byte_count, exp_cnt);
        check("rx_pid", rx_pid, model_pid);
        check("rcving_after_eop", rcving, 0);
        check("writes_missing", exp_q.size(), 0);
    endtask

    initial begin
        logic [3:0] n;
        total     = 0;
        bad       = 0;
        done_seen = 0;
        model_pid = 4'h0;
        prev_we   = 1'b0;
        rst       = 1'b1;
        d_plus    = 1'b1;
        d_minus   = 1'b0;
        fifo_full = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (w_enable) begin
                    if (prev_we) begin
                        total++;
                        bad++;
                        $display("FAIL w_enable_gap: got two consecutive strobes expected isolated strobe");
                    end
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_write: got w_data 0x%0h expected no write", w_data);
                    end else begin
                        check("w_data", w_data, exp_q.pop_front());
                    end
                end
                if (rx_done) done_seen++;
                prev_we = w_enable;
            end
        join_none

        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("reset_w_enable", w_enable, 0);
        check("reset_w_data", w_data, 0);
        check("reset_rcving", rcving, 0);
        check("reset_rx_pid", rx_pid, 0);
        check("reset_rx_done", rx_done, 0);
        check("reset_rx_error", rx_error, 0);
        check("reset_byte_count", byte_count, 0);

        pkt = {8'h3F, 8'hA5};
        send(8'hC3, 1'b1, -1, 0, -1);
        pkt = {8'h12, 8'h34};
        send(8'hC4, 1'b1, -1, 0, -1);
        pkt = {8'h77};
        send(8'h4B, 1'b1, -1, 0, -1);
        pkt = {8'h11, 8'hFF, 8'h22};
        send(8'hC3, 1'b0, -1, 0, -1);
        pkt = {8'($urandom), 8'($urandom), 8'($urandom)};
        send(8'hD2, 1'b1, 1, 0, -1);
        pkt = {8'h5A};
        send(8'hC3, 1'b1, -1, 4, -1);
        pkt = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        send(8'hC3, 1'b1, -1, 0, 16 + 8 * 2 + 3);
        pkt.delete();
        repeat (MAXB) pkt.push_back(8'($urandom));
        send(8'h4B, 1'b1, -1, 0, -1);
        pkt.push_back(8'($urandom));
        send(8'hC3, 1'b1, -1, 0, -1);

        for (int t = 0; t < 12; t++) begin
            n = 4'($urandom);
            pkt.delete();
            repeat ($urandom_range(0, 6)) pkt.push_back(8'($urandom));
            send((t % 5 == 4) ? {n, n} : {~n, n}, 1'b1,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1,
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
